// File: rtl/phone_cmd_decoder_if.sv
// Bus between the phone UART receiver, the command decoder and its consumers.
// The decoder side is the slave; the environment side (UART, transmitter, consumers) is the master.
interface phone_cmd_decoder_if;
  logic [7:0] rx_byte;
  logic       received;
  logic [7:0] heart_cap;
  logic [2:0] assist_level;
  logic [3:0] light_override;
  logic       cmd_valid;
  logic       cmd_error;
  logic       ack_valid;
  logic [7:0] ack_code;
  logic       ack_ready;

  modport slave (
    input  rx_byte, received, ack_ready,
    output heart_cap, assist_level, light_override,
    output cmd_valid, cmd_error, ack_valid, ack_code
  );

  modport master (
    output rx_byte, received, ack_ready,
    input  heart_cap, assist_level, light_override,
    input  cmd_valid, cmd_error, ack_valid, ack_code
  );
endinterface

// File: rtl/phone_cmd_decoder.sv
// Frames the phone byte stream (AA, CMD, LEN, PAYLOAD, CHK), applies accepted
// commands to the rider settings and queues an acknowledge byte for every decision.
module phone_cmd_decoder #(
  parameter int unsigned CLK_HZ         = 50000000,
  parameter int unsigned TIMEOUT_US     = 2000,
  parameter logic [7:0]  HR_CAP_DEFAULT = 8'd200,
  parameter logic [7:0]  HR_CAP_MIN     = 8'd100,
  parameter logic [7:0]  HR_CAP_MAX     = 8'd220,
  parameter logic [2:0]  ASSIST_DEFAULT = 3'd2
) (
  input  logic               CLOCK_50,
  input  logic               reset_n,
  phone_cmd_decoder_if.slave bus
);

  localparam longint unsigned TO_CALC = (64'(TIMEOUT_US) * 64'(CLK_HZ)) / 64'd1000000;
  localparam int unsigned     TO_CYCLES = (TO_CALC < 64'd2) ? 32'd2 : 32'(TO_CALC);
  localparam int              TW = $clog2(TO_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST = TW'(TO_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_LEN, S_PAY, S_CHK} state_t;

  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_cmd;
  logic [2:0]    r_len;
  logic [1:0]    r_idx;
  logic [7:0]    r_pay0;
  logic [7:0]    r_sum;
  logic [7:0]    r_heart_cap;
  logic [2:0]    r_assist;
  logic [3:0]    r_light;
  logic          r_cmd_valid;
  logic          r_cmd_error;
  logic          r_ack_valid;
  logic [7:0]    r_ack_code;

  logic          w_expire;
  logic          w_exec_ok;
  logic [7:0]    w_sum_next;
  logic [7:0]    w_clamped;

  // Expiry wins over a coinciding byte, which is then treated as the first byte seen in IDLE.
  assign w_expire   = (r_state != S_IDLE) && (r_timer == TO_LAST);
  assign w_sum_next = r_sum + bus.rx_byte;
  assign w_clamped  = (r_pay0 < HR_CAP_MIN) ? HR_CAP_MIN :
                      ((r_pay0 > HR_CAP_MAX) ? HR_CAP_MAX : r_pay0);

  always_comb begin
    w_exec_ok = 1'b0;
    case (r_cmd)
      8'h01:   w_exec_ok = (r_len == 3'd1);
      8'h02:   w_exec_ok = (r_len == 3'd1) && (r_pay0 <= 8'd4);
      8'h03:   w_exec_ok = (r_len == 3'd1);
      8'h04:   w_exec_ok = (r_len == 3'd0);
      default: w_exec_ok = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_cmd       <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_pay0      <= '0;
      r_sum       <= '0;
      r_heart_cap <= HR_CAP_DEFAULT;
      r_assist    <= ASSIST_DEFAULT;
      r_light     <= '0;
      r_cmd_valid <= 1'b0;
      r_cmd_error <= 1'b0;
      r_ack_valid <= 1'b0;
      r_ack_code  <= '0;
    end else begin
      r_cmd_valid <= 1'b0;
      r_cmd_error <= 1'b0;

      if (r_ack_valid && bus.ack_ready)
        r_ack_valid <= 1'b0;

      if (bus.received)
        r_timer <= '0;
      else if (r_state != S_IDLE)
        r_timer <= r_timer + TW'(1);

      if (w_expire) begin
        r_cmd_error <= 1'b1;
        r_state     <= (bus.received && (bus.rx_byte == 8'hAA)) ? S_CMD : S_IDLE;
      end else if (bus.received) begin
        case (r_state)
          S_IDLE: begin
            if (bus.rx_byte == 8'hAA)
              r_state <= S_CMD;
          end
          S_CMD: begin
            r_cmd   <= bus.rx_byte;
            r_sum   <= bus.rx_byte;
            r_state <= S_LEN;
          end
          S_LEN: begin
            if (bus.rx_byte > 8'd4) begin
              r_cmd_error <= 1'b1;
              r_ack_valid <= 1'b1;
              r_ack_code  <= {1'b0, r_cmd[6:0]};
              r_state     <= S_IDLE;
            end else begin
              r_len   <= bus.rx_byte[2:0];
              r_sum   <= w_sum_next;
              r_idx   <= '0;
              r_state <= (bus.rx_byte == 8'd0) ? S_CHK : S_PAY;
            end
          end
          S_PAY: begin
            if (r_idx == 2'd0)
              r_pay0 <= bus.rx_byte;
            r_sum <= w_sum_next;
            if ({1'b0, r_idx} == (r_len - 3'd1))
              r_state <= S_CHK;
            else
              r_idx <= r_idx + 2'd1;
          end
          S_CHK: begin
            r_ack_valid <= 1'b1;
            r_state     <= S_IDLE;
            if ((bus.rx_byte == r_sum) && w_exec_ok) begin
              r_cmd_valid <= 1'b1;
              r_ack_code  <= {1'b1, r_cmd[6:0]};
              case (r_cmd)
                8'h01:   r_heart_cap <= w_clamped;
                8'h02:   r_assist    <= r_pay0[2:0];
                8'h03:   r_light     <= r_pay0[3:0];
                default: ;
              endcase
            end else begin
              r_cmd_error <= 1'b1;
              r_ack_code  <= {1'b0, r_cmd[6:0]};
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.heart_cap      = r_heart_cap;
  assign bus.assist_level   = r_assist;
  assign bus.light_override = r_light;
  assign bus.cmd_valid      = r_cmd_valid;
  assign bus.cmd_error      = r_cmd_error;
  assign bus.ack_valid      = r_ack_valid;
  assign bus.ack_code       = r_ack_code;

endmodule
